// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, baud divider helper and
// default line parameters common to the receive and transmit sides.
package uart_pkg;

    localparam int UART_DEFAULT_CLK_FREQ  = 50000000;
    localparam int UART_DEFAULT_BAUD_RATE = 9600;
    localparam int UART_DEFAULT_DATA_BITS = 8;
    localparam int UART_DEFAULT_STOP_BITS = 1;
    localparam int UART_DEFAULT_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PAR       = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } uart_rx_state_t;

    // Clocks per oversample tick, rounded to nearest and never below 1.
    function automatic int uart_baud_div(input int clk_freq, input int baud, input int oversample);
        longint den;
        longint q;
        den = longint'(baud) * longint'(oversample);
        if (den < 1) begin
            return 1;
        end
        q = (longint'(clk_freq) + den / 2) / den;
        if (q < 1) begin
            q = 1;
        end
        return int'(q);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-high reset
//   clear - holds the divider at its reload value (aligns ticks to a start edge)
//   tick  - one-cycle pulse every DIV clocks while clear is low
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Down-counter: terminal count at zero, then reload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || cnt == '0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = (cnt == '0) && !clear;

endmodule

// File: rtl/uart_rx_oversampled.sv
// UART receive front end: 16x-style oversampling, 3-sample majority vote,
// stop-bit check, single-entry holding register on a valid/ready port.
// Optional feature macro: UART_RX_PARITY_EN (even parity bit after the data).
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-high reset
//   rx         - serial line, idle high, asynchronous
//   data       - received character, LSB first on the line
//   data_valid - data holds an unconsumed character
//   data_ready - consumer accepts data
//   frame_err  - one-cycle pulse: bad stop bit (or parity mismatch)
//   overrun    - one-cycle pulse: character dropped, holding register full
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_IDLE      | divider cleared, waiting for synced falling edge
// ST_START     | validating start bit; voted 1 means false start
// ST_DATA      | shifting in DATA_BITS voted bits
// ST_PAR       | sampling even-parity bit (parity builds only)
// ST_STOP      | checking stop bit(s); loads character at last vote point
// ST_WAIT_IDLE | after framing error, wait for line high (break guard)
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = UART_DEFAULT_CLK_FREQ,
    parameter int BAUD_RATE  = UART_DEFAULT_BAUD_RATE,
    parameter int DATA_BITS  = UART_DEFAULT_DATA_BITS,
    parameter int STOP_BITS  = UART_DEFAULT_STOP_BITS,
    parameter int OVERSAMPLE = UART_DEFAULT_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int DIV    = uart_baud_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int SCNT_W = $clog2(OVERSAMPLE);
    localparam int BIDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [SCNT_W-1:0] VOTE_LO   = SCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SCNT_W-1:0] VOTE_MID  = SCNT_W'(OVERSAMPLE / 2);
    localparam logic [SCNT_W-1:0] VOTE_HI   = SCNT_W'(OVERSAMPLE / 2 + 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(OVERSAMPLE - 1);
    localparam logic [BIDX_W-1:0] BIT_LAST  = BIDX_W'(DATA_BITS - 1);
    localparam logic              STOP_LAST = (STOP_BITS == 2);

`ifdef UART_RX_PARITY_EN
    localparam uart_rx_state_t AFTER_DATA = ST_PAR;
`else
    localparam uart_rx_state_t AFTER_DATA = ST_STOP;
`endif

    uart_rx_state_t       state;
    logic                 rx_meta;
    logic                 rx_sync;
    logic                 rx_prev;
    logic [SCNT_W-1:0]    scnt;
    logic [BIDX_W-1:0]    bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 v_lo;
    logic                 v_mid;
    logic                 tick;
    logic                 voted;
    logic                 at_vote;
    logic                 at_wrap;
    logic                 load_req;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad;
`endif

    uart_baud_tick #(
        .DIV(DIV)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .clear(state == ST_IDLE),
        .tick (tick)
    );

    // Third sample is the live synced value at the decision point.
    assign voted   = (v_lo & v_mid) | (v_lo & rx_sync) | (v_mid & rx_sync);
    assign at_vote = tick && (scnt == VOTE_HI);
    assign at_wrap = tick && (scnt == SCNT_LAST);

`ifdef UART_RX_PARITY_EN
    assign load_req = (state == ST_STOP) && at_vote && voted && (stop_idx == STOP_LAST) && !par_bad;
`else
    assign load_req = (state == ST_STOP) && at_vote && voted && (stop_idx == STOP_LAST);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            scnt       <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shreg      <= '0;
            v_lo       <= 1'b1;
            v_mid      <= 1'b1;
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
`endif
        end else begin
            rx_meta   <= rx;
            rx_sync   <= rx_meta;
            rx_prev   <= rx_sync;
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            if (tick && scnt == VOTE_LO) begin
                v_lo <= rx_sync;
            end
            if (tick && scnt == VOTE_MID) begin
                v_mid <= rx_sync;
            end

            if (state == ST_IDLE) begin
                scnt <= '0;
            end else if (tick) begin
                scnt <= (scnt == SCNT_LAST) ? '0 : scnt + 1'b1;
            end

            // A pending transfer frees the register for a same-cycle load.
            if (load_req) begin
                if (!data_valid || data_ready) begin
                    data       <= shreg;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        state <= ST_START;
`ifdef UART_RX_PARITY_EN
                        par_bad <= 1'b0;
`endif
                    end
                end
                ST_START: begin
                    if (at_vote && voted) begin
                        state <= ST_IDLE;
                    end else if (at_wrap) begin
                        state   <= ST_DATA;
                        bit_idx <= '0;
                    end
                end
                ST_DATA: begin
                    if (at_vote) begin
                        shreg <= {voted, shreg[DATA_BITS-1:1]};
                    end
                    if (at_wrap) begin
                        if (bit_idx == BIT_LAST) begin
                            state    <= AFTER_DATA;
                            stop_idx <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PAR: begin
                    if (at_vote && (voted != ^shreg)) begin
                        frame_err <= 1'b1;
                        par_bad   <= 1'b1;
                    end
                    if (at_wrap) begin
                        state    <= ST_STOP;
                        stop_idx <= 1'b0;
                    end
                end
`endif
                ST_STOP: begin
                    if (at_vote) begin
                        if (!voted) begin
                            frame_err <= 1'b1;
                            state     <= ST_WAIT_IDLE;
                        end else if (stop_idx == STOP_LAST) begin
                            // Leave mid stop bit so a following start edge is caught.
                            state <= ST_IDLE;
                        end
                    end else if (at_wrap) begin
                        stop_idx <= 1'b1;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (rx_sync) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
